// File: rtl/dlx_pkg.sv
// Shared DLX integer-pipeline constants, types and small decode helpers.
package dlx_pkg;

  localparam int NREG = 32;
  localparam int W    = 32;
  localparam int SW   = 5;

  typedef logic [W-1:0]    word_t;
  typedef logic [SW-1:0]   sel_t;
  typedef logic [NREG-1:0] regvec_t;

  localparam sel_t ZERO_REG = '0;

  // One-hot decode of a register index.
  function automatic regvec_t dec_n(input sel_t sel);
    regvec_t v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy scoreboard: one bit per architectural register, set on issue of a
// destination, cleared on its writeback. R0 is never busy.
module reg_scoreboard
  import dlx_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  logic    set_en,
  input  sel_t    set_sel,
  input  logic    clr_en,
  input  sel_t    clr_sel,
  output regvec_t busy,
  output regvec_t busy_eff
);

  regvec_t set_vec;
  regvec_t clr_vec;
  regvec_t busy_next;

  // Decode set/clear strobes; a writeback this cycle hides its busy bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    set_vec   = '0;
    clr_vec   = '0;
    if (set_en) set_vec = dec_n(set_sel);
    if (clr_en) clr_vec = dec_n(clr_sel);
    busy_eff  = busy & ~clr_vec;
    // Set is applied after clear so a coincident set on the same index wins.
    busy_next = busy_eff | set_vec;
    busy_next[ZERO_REG] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset_n) busy <= '0;
    else          busy <= busy_next;
  end

endmodule

// File: rtl/read_reg.sv
// Register-file read side: operand read with R0 and writeback bypass,
// RAW/WAW hazard stall against the busy scoreboard, one-deep registered
// output toward EX with valid/ready, and a saturating stall-cycle counter.
module read_reg
  import dlx_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [SW-1:0]    rs1_sel,
  input  logic [SW-1:0]    rs2_sel,
  input  logic             use_rs2,
  input  logic             dest_en,
  input  logic [SW-1:0]    dest_sel,
  input  logic             wb_en,
  input  logic [SW-1:0]    wb_sel,
  input  logic [W-1:0]     wb_data,
  input  logic [W-1:0]     r0,  r1,  r2,  r3,  r4,  r5,  r6,  r7,
  input  logic [W-1:0]     r8,  r9,  r10, r11, r12, r13, r14, r15,
  input  logic [W-1:0]     r16, r17, r18, r19, r20, r21, r22, r23,
  input  logic [W-1:0]     r24, r25, r26, r27, r28, r29, r30, r31,
  output logic             out_valid,
  input  logic             ex_ready,
  output logic [W-1:0]     a_out,
  output logic [W-1:0]     b_out,
  output logic [NREG-1:0]  busy,
  output logic [CNT_W-1:0] stall_cnt
);

  word_t   r_arr [NREG];
  word_t   rs1_val;
  word_t   rs2_val;
  regvec_t busy_eff;
  logic    hazard;
  logic    accept;

  assign r_arr[0]  = r0;  assign r_arr[1]  = r1;  assign r_arr[2]  = r2;  assign r_arr[3]  = r3;
  assign r_arr[4]  = r4;  assign r_arr[5]  = r5;  assign r_arr[6]  = r6;  assign r_arr[7]  = r7;
  assign r_arr[8]  = r8;  assign r_arr[9]  = r9;  assign r_arr[10] = r10; assign r_arr[11] = r11;
  assign r_arr[12] = r12; assign r_arr[13] = r13; assign r_arr[14] = r14; assign r_arr[15] = r15;
  assign r_arr[16] = r16; assign r_arr[17] = r17; assign r_arr[18] = r18; assign r_arr[19] = r19;
  assign r_arr[20] = r20; assign r_arr[21] = r21; assign r_arr[22] = r22; assign r_arr[23] = r23;
  assign r_arr[24] = r24; assign r_arr[25] = r25; assign r_arr[26] = r26; assign r_arr[27] = r27;
  assign r_arr[28] = r28; assign r_arr[29] = r29; assign r_arr[30] = r30; assign r_arr[31] = r31;

  // 32-way read with R0 forced to zero and same-cycle writeback bypass.
  function automatic word_t read_operand(input sel_t  sel,
                                         input word_t reg_val,
                                         input logic  wb_hit,
                                         input word_t wb_val);
    if (sel == ZERO_REG) return '0;
    if (wb_hit)          return wb_val;
    return reg_val;
  endfunction

  reg_scoreboard u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_en   (accept && dest_en),
    .set_sel  (dest_sel),
    .clr_en   (wb_en),
    .clr_sel  (wb_sel),
    .busy     (busy),
    .busy_eff (busy_eff)
  );

  // Operand read, hazard detection and request acceptance.
  always_comb begin
    rs1_val  = read_operand(rs1_sel, r_arr[rs1_sel], wb_en && (wb_sel == rs1_sel), wb_data);
    rs2_val  = read_operand(rs2_sel, r_arr[rs2_sel], wb_en && (wb_sel == rs2_sel), wb_data);
    hazard   = ((rs1_sel != ZERO_REG) && busy_eff[rs1_sel])
            || (use_rs2 && (rs2_sel != ZERO_REG) && busy_eff[rs2_sel])
            || (dest_en && (dest_sel != ZERO_REG) && busy_eff[dest_sel]);
    rd_ready = !hazard && (!out_valid || ex_ready);
    accept   = rd_valid && rd_ready;
  end

  // One-deep output stage: load on accept, drain on EX handshake, else hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      a_out     <= rs1_val;
      b_out     <= rs2_val;
    end else if (ex_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of cycles a valid request is held off by a hazard.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cnt <= '0;
    else if (rd_valid && hazard && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: doc/read_reg.md
# read_reg

Register-file read side of the DLX integer pipeline, the counterpart to the write path. Each cycle it accepts one ID-stage operand request, reads two source registers (R0 hard-wired to zero), bypasses a same-cycle writeback, and presents the operands in a one-deep registered output with a valid/ready handshake. A 32-entry busy scoreboard tracks destinations that have been issued but not yet written back. The block stalls requests on RAW/WAW hazards and counts stall cycles.

## Interface
- NREG, 32, number of architectural registers
- W, 32, data width
- SW, 5, select width (log2 NREG)
- CNT_W, 16, stall counter width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- rd_valid  in  1  ID request valid
- rd_ready  out  1  request accepted this cycle when rd_valid && rd_ready
- rs1_sel, rs2_sel  in  SW  source selects
- use_rs2  in  1  rs2 is a real source; when 0 it is excluded from hazard check
- dest_en  in  1  request writes a destination
- dest_sel  in  SW  destination select
- wb_en  in  1  writeback strobe, the same strobe that drives the write path
- wb_sel  in  SW  writeback select
- wb_data  in  W  writeback data
- r0..r31  in  W each  current register contents from the write path
- out_valid  out  1  operands valid toward EX
- ex_ready  in  1  EX accepts operands
- a_out, b_out  out  W  registered operands
- busy  out  NREG  scoreboard; bit 0 constant 0
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- Operand read: a source select of 0 yields 0. If wb_en && wb_sel==sel && sel!=0, the operand is wb_data (bypass). Otherwise it is r[sel].
- Effective busy: `busy_eff[i] = busy[i] && !(wb_en && wb_sel==i)`.
- Hazard: asserted when any of the following holds:
  - rs1_sel!=0 && busy_eff[rs1_sel]
  - use_rs2 && rs2_sel!=0 && busy_eff[rs2_sel]
  - dest_en && dest_sel!=0 && busy_eff[dest_sel]
- Ready: `rd_ready = !hazard && (!out_valid || ex_ready)`. rd_ready is combinational and may depend on rd_valid-side selects.
- Accept: a_out/b_out load the operands and out_valid sets to 1. When use_rs2=0, b_out loads the rs2 read anyway.
- Output handshake:
  - out_valid && ex_ready with no accept in the same cycle clears out_valid.
  - If out_valid && !ex_ready, a_out/b_out/out_valid hold.
- Scoreboard, per bit i!=0, evaluated each cycle:
  - set when the accepted request has dest_en && dest_sel==i
  - clear when wb_en && wb_sel==i
  - set wins when set and clear coincide on the same index
- stall_cnt increments by 1 each cycle with rd_valid && hazard, and saturates at all-ones.
- Backpressure-only stalls (hazard=0, output full) are not counted.
- A request whose dest_sel equals one of its own sources reads the pre-update value. There is no self-hazard.

## Timing
- Reset (asynchronous, effective immediately) drives out_valid=0, a_out=0, b_out=0, busy=0 and stall_cnt=0. Reset asserted mid-transfer drops any held operands without handshake.
- Read latency is 1 cycle: operands accepted at edge N appear on a_out/b_out after edge N.
- Throughput is 1 request/cycle when ex_ready is held 1 and there is no hazard.
- Writeback at edge N is visible through the bypass in the same cycle. It is visible via r[] from cycle N+1.
- The busy bit set by an accept at edge N is visible to the request presented in cycle N+1.
- Writeback to R0 is ignored by both the bypass and the scoreboard.

## Structure
- Shared package `dlx_pkg` holds NREG, W, SW and the constant ZERO_REG=0.
- Sub-module `reg_scoreboard`:
  - holds the NREG-bit busy vector with set/clear logic
  - generates busy_eff
  - decodes indices with the existing dec_n
- Operand selection reuses the existing 32-way read mux style, with bypass via mux_32.

## Test plan
- Reset mid-stream: out_valid=1 and busy=32'h0000_0010, then reset_n=0 -> outputs 0, busy=0 immediately, rd_ready=1 after release.
- Basic read: r3=32'h1234_5678, r7=32'hDEAD_BEEF, rs1=3, rs2=7, ex_ready=1 -> next cycle a_out=32'h1234_5678, b_out=32'hDEAD_BEEF, out_valid=1.
- R0 and bypass:
  - rs1=0, rs2=5, r5=32'h1, wb_en=1, wb_sel=5, wb_data=32'hCAFE_0005 -> a_out=0, b_out=32'hCAFE_0005.
  - wb_sel=0 -> b_out=32'h1.
- RAW stall:
  - Accept dest_sel=9, dest_en=1 -> busy[9]=1.
  - Next request rs1=9 -> rd_ready=0 and stall_cnt increments each cycle.
  - wb_en=1, wb_sel=9, wb_data=32'h99 -> accepted that cycle with a_out=32'h99, busy[9]=0.
- Set/clear collision: busy[4]=1, then wb_sel=4 while an accepted request has dest_sel=4 -> busy[4] stays 1.
- Backpressure: out_valid=1, ex_ready=0 for 3 cycles -> a_out/b_out hold, rd_ready=0, stall_cnt unchanged.
